cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter s_line, default 256, cacheline width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port icache_pmem_read  input  1  I-cache line-fill request.
REQ-005 SHALL have port icache_pmem_address  input  32  I-cache line address.
REQ-006 SHALL have port icache_pmem_rdata  output  s_line  fill data to I-cache.
REQ-007 SHALL have port icache_pmem_resp  output  1  I-cache transfer complete.
REQ-008 SHALL have port dcache_pmem_read  input  1  D-cache line-fill request.
REQ-009 SHALL have port dcache_pmem_write  input  1  D-cache writeback request.
REQ-010 SHALL have port dcache_pmem_wdata  input  s_line  writeback data.
REQ-011 SHALL have port dcache_pmem_address  input  32  D-cache line address.
REQ-012 SHALL have port dcache_pmem_rdata  output  s_line  fill data to D-cache.
REQ-013 SHALL have port dcache_pmem_resp  output  1  D-cache transfer complete.
REQ-014 SHALL have ports pmem_read and pmem_write, each output 1; read or write request to the cacheline adapter.
REQ-015 SHALL have ports pmem_address (output 32) and pmem_wdata (output s_line); request address and data to the adapter.
REQ-016 SHALL have ports pmem_rdata (input s_line) and pmem_resp (input 1); adapter data and completion.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE.
REQ-018 IDLE: SHALL latch address, wdata and op of the selected requester and move to SERVE_I or SERVE_D at the next edge; with no request, SHALL stay in IDLE.
REQ-019 Simultaneous I and D requests in IDLE: SHALL grant the requester not served last (round-robin); last_grant resets to I, so D wins the first tie.
REQ-020 D-cache read and write asserted together: SHALL perform the write.
REQ-021 pmem_read/pmem_write SHALL be registered and asserted only in SERVE_I/SERVE_D: a request sampled at edge k gives a downstream request in cycle k+1; SERVE_I always issues a read.
REQ-022 pmem_address and pmem_wdata SHALL come from the latch and hold stable for the whole SERVE state, independent of requester input changes.
REQ-023 pmem_rdata SHALL feed both icache_pmem_rdata and dcache_pmem_rdata unconditionally.
REQ-024 icache_pmem_resp SHALL equal pmem_resp AND (state==SERVE_I), combinationally; dcache_pmem_resp likewise for SERVE_D; both SHALL be 0 in every other state.
REQ-025 On pmem_resp in SERVE_x: SHALL update last_grant, go to DONE, and drop pmem_read/pmem_write at the next edge.
REQ-026 DONE SHALL last exactly one cycle, ignore all requests (stale request from the just-served cache), then go to IDLE.
REQ-027 pmem_resp in IDLE or DONE SHALL be ignored, with no state change and no resp to either cache.
REQ-028 Back-to-back: a request pending during SERVE/DONE SHALL be granted in IDLE; minimum gap between downstream transactions is 2 cycles (DONE, IDLE).
REQ-029 The arbiter SHALL never assert pmem_read and pmem_write together.

Reset
REQ-030 rst high at an edge SHALL force state IDLE, last_grant I, pmem_read=0, pmem_write=0, latched address/wdata=0; icache_pmem_resp=dcache_pmem_resp=0 in the following cycle.
REQ-031 Reset mid-transaction SHALL abandon it with no resp; the adapter and caches reset in the same cycle.

Structure
REQ-032 A shared package (cache_arbiter_types) SHALL hold the FSM state enum and the grant enum (GRANT_I, GRANT_D).
REQ-033 SHALL have no sub-module; arbitration logic SHALL be inline.

Verification
REQ-034 I read 0x0000_1000 only, adapter resp after 4 cycles -> pmem_read in cycle 1, pmem_address 0x1000, icache_pmem_resp single pulse, dcache_pmem_resp 0.
REQ-035 After reset, I read 0x100 and D read 0x200 in same cycle -> D served first (address 0x200), then I (0x100) after DONE+IDLE; alternation holds over 3 more collision pairs.
REQ-036 D write 0x300, wdata 0xA5 repeated -> pmem_write=1 and pmem_wdata stable throughout while dcache inputs toggle; D read+write together -> write issued.
REQ-037 Requester holds read 1 cycle past its resp -> DONE absorbs it; no second transaction to the same address.
REQ-038 rst asserted mid SERVE_D -> next cycle IDLE, pmem_write=0, no resp pulse; a new I request is then served normally.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to cacheline-adapter arbiter.
// Holds the arbiter FSM state encoding and the grant identifiers.
package cache_arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adapter between the I-cache and D-cache.
// One transaction at a time: IDLE -> SERVE_x -> DONE -> IDLE.
module cache_arbiter
    import cache_arbiter_types::*;
#(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_pmem_read,
    input  logic [31:0]       icache_pmem_address,
    output logic [s_line-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,

    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [s_line-1:0] dcache_pmem_wdata,
    input  logic [31:0]       dcache_pmem_address,
    output logic [s_line-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [1:0]        state_dbg
);

    // Handshake: a cache holds its read/write level until it sees a one-cycle
    // resp; the adapter side is the same, with pmem_read/pmem_write held until
    // pmem_resp. Requests seen while not in IDLE wait; the DONE cycle lets the
    // just-served cache drop its stale request before the next grant.

    arb_state_t        state, state_next;
    grant_t            last_grant, last_grant_next;
    grant_t            pick;
    logic [31:0]       addr_q, addr_next;
    logic [s_line-1:0] wdata_q, wdata_next;
    logic              read_q, read_next;
    logic              write_q, write_next;
    logic              d_req;

    assign d_req = dcache_pmem_read | dcache_pmem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            read_q     <= read_next;
            write_q    <= write_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        read_next       = read_q;
        write_next      = write_q;

        // On a tie the side that was not served last wins.
        pick = GRANT_I;
        if (d_req && (!icache_pmem_read || last_grant == GRANT_I)) begin
            pick = GRANT_D;
        end

        unique case (state)
            IDLE: begin
                if (pick == GRANT_D) begin
                    state_next = SERVE_D;
                    addr_next  = dcache_pmem_address;
                    wdata_next = dcache_pmem_wdata;
                    // A simultaneous read+write from the D-cache is a writeback.
                    write_next = dcache_pmem_write;
                    read_next  = ~dcache_pmem_write;
                end else if (icache_pmem_read) begin
                    state_next = SERVE_I;
                    addr_next  = icache_pmem_address;
                    wdata_next = '0;
                    write_next = 1'b0;
                    read_next  = 1'b1;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next      = DONE;
                    last_grant_next = GRANT_I;
                    read_next       = 1'b0;
                    write_next      = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next      = DONE;
                    last_grant_next = GRANT_D;
                    read_next       = 1'b0;
                    write_next      = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;
    assign icache_pmem_resp  = pmem_resp & (state == SERVE_I);
    assign dcache_pmem_resp  = pmem_resp & (state == SERVE_D);

    assign state_dbg = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: two cache requesters, a cacheline-adapter model with
// random latency, and a transaction-level round-robin reference model.
module tb_cache_arbiter;
    import cache_arbiter_types::*;

    localparam int S = 256;
    localparam int W = 1 + 32 + S;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_pmem_read;
    logic [31:0]  icache_pmem_address;
    logic [S-1:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [S-1:0] dcache_pmem_wdata;
    logic [31:0]  dcache_pmem_address;
    logic [S-1:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [S-1:0] pmem_wdata;
    logic [S-1:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   state_dbg;

    cache_arbiter #(.s_line(S)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp),
        .state_dbg           (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_start[$];
    int           obs_resp[$];
    int           n_checks = 0;
    int           n_pass = 0;
    bit           model_last_d = 1'b0;

    int i_resp_cnt = 0, d_resp_cnt = 0, rw_both_cnt = 0;
    int orphan_cnt = 0, rdata_bad = 0, unstable_cnt = 0;

    // ---------------- adapter model ----------------
    bit           busy = 1'b0;
    bit           force_resp = 1'b0;
    int           cnt = 0, cur_lat = 1, lat_fixed = 0;
    logic [31:0]  hold_addr;
    logic [S-1:0] hold_wdata;
    logic         hold_rd, hold_wr;

    function automatic logic [W-1:0] pack_txn(input bit wr, input logic [31:0] a, input logic [S-1:0] d);
        return {wr, a, wr ? d : {S{1'b0}}};
    endfunction

    function automatic logic [S-1:0] rand_line();
        logic [S-1:0] r;
        for (int i = 0; i < S / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                busy      = 1'b0;
            end else if (busy && !(pmem_read || pmem_write)) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = rand_line();
                    obs_resp[obs_resp.size() - 1] = cyc;
                end
            end
            if (!busy && !pmem_resp) begin
                if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
                    busy       = 1'b1;
                    cnt        = 0;
                    cur_lat    = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 5);
                    hold_addr  = pmem_address;
                    hold_wdata = pmem_wdata;
                    hold_rd    = pmem_read;
                    hold_wr    = pmem_write;
                    obs_q.push_back(pack_txn(pmem_write, pmem_address, pmem_wdata));
                    obs_start.push_back(cyc);
                    obs_resp.push_back(-1);
                end else begin
                    pmem_resp = force_resp;
                end
            end
        end
    end

    // ---------------- passive monitor ----------------
    always @(negedge clk) begin
        if (pmem_read === 1'b1 && pmem_write === 1'b1) rw_both_cnt <= rw_both_cnt + 1;
        if (icache_pmem_resp === 1'b1) i_resp_cnt <= i_resp_cnt + 1;
        if (dcache_pmem_resp === 1'b1) d_resp_cnt <= d_resp_cnt + 1;
        if ((icache_pmem_resp === 1'b1 || dcache_pmem_resp === 1'b1) && pmem_resp !== 1'b1)
            orphan_cnt <= orphan_cnt + 1;
        if (icache_pmem_resp === 1'b1 && dcache_pmem_resp === 1'b1) orphan_cnt <= orphan_cnt + 1;
        if (icache_pmem_rdata !== pmem_rdata || dcache_pmem_rdata !== pmem_rdata) rdata_bad <= rdata_bad + 1;
        if (busy && (pmem_address !== hold_addr || pmem_wdata !== hold_wdata ||
                     pmem_read !== hold_rd || pmem_write !== hold_wr))
            unstable_cnt <= unstable_cnt + 1;
    end

    // ---------------- driver + reference model ----------------
    task automatic run_pair(input bit iv, input logic [31:0] ia, input bit dv, input bit dr,
                            input bit dw, input logic [31:0] da, input logic [S-1:0] dwd,
                            input int hold, input bit toggle, input string tag);
        bit           d_first, i_pend, d_pend;
        int           n_exp, base, drive_cyc, i0, d0, uns0, i_hold, d_hold;
        logic [W-1:0] e, o, txn_i, txn_d;
        txn_i   = pack_txn(1'b0, ia, '0);
        txn_d   = pack_txn(dw, da, dwd);
        d_first = dv && (!iv || !model_last_d);
        n_exp   = int'(iv) + int'(dv);
        if (d_first) begin
            exp_q.push_back(txn_d);
            if (iv) exp_q.push_back(txn_i);
        end else begin
            if (iv) exp_q.push_back(txn_i);
            if (dv) exp_q.push_back(txn_d);
        end
        model_last_d = (iv && dv) ? !d_first : dv;

        base = obs_q.size(); i0 = i_resp_cnt; d0 = d_resp_cnt; uns0 = unstable_cnt;
        @(posedge clk); #1;
        drive_cyc           = cyc;
        icache_pmem_read    = iv;
        icache_pmem_address = ia;
        dcache_pmem_read    = dv & dr;
        dcache_pmem_write   = dv & dw;
        dcache_pmem_address = da;
        dcache_pmem_wdata   = dwd;
        i_pend = iv; d_pend = dv; i_hold = 0; d_hold = 0;
        for (int t = 0; t < 300 && (i_pend || d_pend || i_hold > 0 || d_hold > 0); t++) begin
            @(negedge clk);
            if (i_pend && icache_pmem_resp === 1'b1) begin i_pend = 0; i_hold = hold + 1; end
            if (d_pend && dcache_pmem_resp === 1'b1) begin d_pend = 0; d_hold = hold + 1; end
            @(posedge clk); #1;
            if (i_hold > 0) begin
                i_hold--;
                if (i_hold == 0) icache_pmem_read = 1'b0;
            end
            if (d_hold > 0) begin
                d_hold--;
                if (d_hold == 0) begin dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0; end
            end
            if (toggle && d_pend) begin
                dcache_pmem_address = $urandom;
                dcache_pmem_wdata   = rand_line();
                dcache_pmem_read    = 1'($urandom_range(0, 1));
            end
        end
        icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;

        n_checks++;
        if (i_pend || d_pend) $display("FAIL %s timeout: i_pending=%0d d_pending=%0d", tag, i_pend, d_pend);
        else n_pass++;

        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (obs_q.size() - base !== n_exp)
            $display("FAIL %s txn_count: got %0d expected %0d", tag, obs_q.size() - base, n_exp);
        else n_pass++;
        for (int k = 0; k < n_exp; k++) begin
            e = exp_q.pop_front();
            o = (base + k < obs_q.size()) ? obs_q[base + k] : 'x;
            n_checks++;
            if (o !== e) $display("FAIL %s txn%0d: got %h expected %h", tag, k, o, e);
            else n_pass++;
        end
        if (obs_q.size() > base) begin
            n_checks++;
            if (obs_start[base] !== drive_cyc + 1)
                $display("FAIL %s latency: start cycle %0d expected %0d", tag, obs_start[base], drive_cyc + 1);
            else n_pass++;
        end
        if (n_exp == 2 && obs_q.size() >= base + 2) begin
            n_checks++;
            if (obs_start[base + 1] !== obs_resp[base] + 3)
                $display("FAIL %s gap: second start %0d expected %0d", tag, obs_start[base + 1], obs_resp[base] + 3);
            else n_pass++;
        end
        n_checks++;
        if (i_resp_cnt - i0 !== int'(iv) || d_resp_cnt - d0 !== int'(dv))
            $display("FAIL %s resp_pulses: i=%0d d=%0d expected i=%0d d=%0d", tag,
                     i_resp_cnt - i0, d_resp_cnt - d0, iv, dv);
        else n_pass++;
        n_checks++;
        if (unstable_cnt !== uns0)
            $display("FAIL %s stability: %0d unstable cycles expected 0", tag, unstable_cnt - uns0);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; force_resp = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL reset_req: read=%b write=%b expected 0 0", pmem_read, pmem_write);
        else n_pass++;
        n_checks++;
        if (pmem_address !== 32'h0 || pmem_wdata !== '0)
            $display("FAIL reset_latch: addr=%h expected 0", pmem_address);
        else n_pass++;
        n_checks++;
        if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0)
            $display("FAIL reset_resp: i=%b d=%b expected 0 0", icache_pmem_resp, dcache_pmem_resp);
        else n_pass++;
        n_checks++;
        if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
        else n_pass++;
        rst = 1'b0; force_resp = 1'b0;
        model_last_d = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_i();
        lat_fixed = 4;
        run_pair(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, '0, 0, 1'b0, "i_read_1000");
        lat_fixed = 0;
    endtask

    task automatic test_collision();
        run_pair(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0200, '0, 0, 1'b0, "collide_first");
        for (int n = 0; n < 3; n++)
            run_pair(1'b1, $urandom & 32'hFFFF_FFE0, 1'b1, 1'b1, 1'b0, $urandom & 32'hFFFF_FFE0,
                     '0, 0, 1'b0, "collide_more");
    endtask

    task automatic test_write_stable();
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, {(S/8){8'hA5}}, 0, 1'b1, "d_write_a5");
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0340, rand_line(), 0, 1'b0, "d_read_and_write");
    endtask

    task automatic test_hold_past_resp();
        run_pair(1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1, 1'b0, "i_hold");
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_2100, '0, 1, 1'b0, "d_hold");
        run_pair(1'b1, 32'h0000_2200, 1'b1, 1'b0, 1'b1, 32'h0000_2300, rand_line(), 1, 1'b0, "pair_hold");
    endtask

    task automatic test_spurious_resp();
        int base, i0, d0;
        base = obs_q.size(); i0 = i_resp_cnt; d0 = d_resp_cnt;
        @(negedge clk);
        force_resp = 1'b1;
        repeat (4) @(negedge clk);
        force_resp = 1'b0;
        n_checks++;
        if (i_resp_cnt !== i0 || d_resp_cnt !== d0)
            $display("FAIL idle_resp_pulse: i=%0d d=%0d expected 0 0", i_resp_cnt - i0, d_resp_cnt - d0);
        else n_pass++;
        n_checks++;
        if (state_dbg !== IDLE || obs_q.size() !== base)
            $display("FAIL idle_resp_state: state=%0d new_txns=%0d expected %0d 0", state_dbg,
                     obs_q.size() - base, IDLE);
        else n_pass++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_serve();
        int           base, d0;
        logic [S-1:0] wd;
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, '0, 0, 1'b0, "pre_reset_d");
        lat_fixed = 10;
        wd = rand_line();
        base = obs_q.size(); d0 = d_resp_cnt;
        @(posedge clk); #1;
        dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_0400; dcache_pmem_wdata = wd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pmem_write !== 1'b1 || state_dbg !== SERVE_D)
            $display("FAIL mid_serve: write=%b state=%0d expected 1 %0d", pmem_write, state_dbg, SERVE_D);
        else n_pass++;
        rst = 1'b1; dcache_pmem_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || state_dbg !== IDLE)
            $display("FAIL abort: write=%b read=%b state=%0d expected 0 0 %0d", pmem_write, pmem_read,
                     state_dbg, IDLE);
        else n_pass++;
        rst = 1'b0; lat_fixed = 0;
        model_last_d = 1'b0;
        repeat (12) @(posedge clk); #1;
        n_checks++;
        if (d_resp_cnt !== d0) $display("FAIL abort_resp: got %0d pulses expected 0", d_resp_cnt - d0);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== base + 1 || obs_q[base] !== pack_txn(1'b1, 32'h0000_0400, wd))
            $display("FAIL abort_txn: new_txns=%0d expected 1 write to 00000400", obs_q.size() - base);
        else n_pass++;
        run_pair(1'b1, 32'h0000_0600, 1'b1, 1'b1, 1'b0, 32'h0000_0700, '0, 0, 1'b0, "post_reset_tie");
        run_pair(1'b1, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 32'h0, '0, 0, 1'b0, "post_reset_i");
    endtask

    task automatic test_random();
        bit iv, dv, dr, dw;
        for (int n = 0; n < 20; n++) begin
            iv = 1'($urandom_range(0, 1));
            dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            dr = 1'($urandom_range(0, 1));
            dw = dr ? 1'($urandom_range(0, 1)) : 1'b1;
            run_pair(iv, $urandom & 32'hFFFF_FFE0, dv, dr, dw, $urandom & 32'hFFFF_FFE0, rand_line(),
                     $urandom_range(0, 1), !iv, "random");
        end
    endtask

    task automatic test_monitor_totals();
        n_checks++;
        if (rw_both_cnt !== 0) $display("FAIL read_and_write: %0d cycles expected 0", rw_both_cnt);
        else n_pass++;
        n_checks++;
        if (orphan_cnt !== 0) $display("FAIL orphan_resp: %0d cycles expected 0", orphan_cnt);
        else n_pass++;
        n_checks++;
        if (rdata_bad !== 0) $display("FAIL rdata_passthru: %0d cycles expected 0", rdata_bad);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        icache_pmem_read = 1'b0; icache_pmem_address = '0;
        dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        test_reset();
        test_single_i();
        test_collision();
        test_write_stable();
        test_hold_past_resp();
        test_spurious_resp();
        test_reset_mid_serve();
        test_random();
        test_monitor_totals();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
